// File: rtl/digit_scan_if.sv
// digit_scan_if: scan controls in, decoder drive and frame pulse out
interface digit_scan_if;
    logic        run;
    logic [15:0] digits;
    logic [3:0]  blank_mask;
    logic        sel_a;
    logic        sel_b;
    logic        dec_en;
    logic [3:0]  nibble;
    logic        frame_done;
    modport master (output run, digits, blank_mask, input sel_a, sel_b, dec_en, nibble, frame_done);
    modport slave  (input run, digits, blank_mask, output sel_a, sel_b, dec_en, nibble, frame_done);
endinterface

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: 4-digit multiplexed scan with a blanking gap before every digit
module digit_scan_ctrl #(
    parameter int PRESCALE  = 1000,
    parameter int BLANK_CYC = 16
) (
    input logic        clk,
    input logic        rst,
    digit_scan_if.slave bus
);
    localparam int MAXC = PRESCALE > BLANK_CYC ? PRESCALE : BLANK_CYC;
    localparam int CW   = $clog2(MAXC);
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    state_t        state, nxt_state;
    logic [1:0]    idx, nxt_idx;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          blank_last, show_last, en_d, fd_d;
    logic          dec_en, frame_done;
    logic [3:0]    nibble, nib_d;
    assign blank_last = cnt == CW'(BLANK_CYC - 1);
    assign show_last  = cnt == CW'(PRESCALE - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            dec_en     <= 1'b0;
            frame_done <= 1'b0;
            nibble     <= '0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            cnt        <= nxt_cnt;
            dec_en     <= en_d;
            frame_done <= fd_d;
            nibble     <= nib_d;
        end
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt + 1'b1;
        if (!bus.run) begin
            nxt_state = IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else if (state != BLANK && state != SHOW) begin
            nxt_state = BLANK;
            nxt_idx   = '0;
            nxt_cnt   = '0;
        end else if (state == BLANK && blank_last) begin
            nxt_state = SHOW;
            nxt_cnt   = '0;
        end else if (state == SHOW && show_last) begin
            nxt_state = BLANK;
            nxt_idx   = idx + 1'b1;
            nxt_cnt   = '0;
        end
    end
    // outputs are registered from the next-state values so they line up with the state they describe
    always_comb begin
        en_d  = nxt_state == SHOW && !bus.blank_mask[nxt_idx];
        fd_d  = nxt_state == SHOW && nxt_idx == 2'd3 && nxt_cnt == CW'(PRESCALE - 1);
        nib_d = (state == BLANK && nxt_state == SHOW) ? bus.digits[{idx, 2'b00} +: 4] : nibble;
    end
    assign bus.sel_a      = idx[1];
    assign bus.sel_b      = idx[0];
    assign bus.dec_en     = dec_en;
    assign bus.frame_done = frame_done;
    assign bus.nibble     = nibble;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed checks of scan order, masking, digit latching, stop/restart and reset
module tb_digit_scan_ctrl;
    localparam int PRESCALE  = 4;
    localparam int BLANK_CYC = 2;
    localparam int SLOT      = PRESCALE + BLANK_CYC;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic prev_en = 1'b0;
    logic [1:0] prev_sel = 2'b00;
    int run_len = 0;
    digit_scan_if bus();
    digit_scan_ctrl #(.PRESCALE(PRESCALE), .BLANK_CYC(BLANK_CYC)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // k counts edges since run rose: BLANK_CYC blank cycles, then PRESCALE show cycles, per digit
    task automatic expect_step(input string tag, input int k, input logic [3:0] m, input logic [15:0] d);
        int p;
        int s;
        p = (k - 1) % SLOT;
        s = ((k - 1) / SLOT) % 4;
        check({tag, "_en"}, 32'(bus.dec_en), 32'(p >= BLANK_CYC && !m[s]));
        check({tag, "_sel"}, 32'({bus.sel_a, bus.sel_b}), 32'(s));
        if (p >= BLANK_CYC) check({tag, "_nib"}, 32'(bus.nibble), 32'(d[4*s +: 4]));
        check({tag, "_fd"}, 32'(bus.frame_done), 32'(p == SLOT - 1 && s == 3));
    endtask
    task automatic restart;
        bus.run = 1'b0;
        tick;
        bus.run = 1'b1;
    endtask
    always @(negedge clk) begin
        if (rst) begin
            prev_en <= 1'b0;
            run_len <= 0;
        end else begin
            if (prev_en && bus.dec_en) check("glitch_sel", 32'({bus.sel_a, bus.sel_b}), 32'(prev_sel));
            if (prev_en && !bus.dec_en && bus.run) check("en_len", 32'(run_len), 32'(PRESCALE));
            run_len  <= bus.dec_en ? run_len + 1 : 0;
            prev_en  <= bus.dec_en;
            prev_sel <= {bus.sel_a, bus.sel_b};
        end
    end
    initial begin
        bus.run = 1'b0;
        bus.digits = 16'h4321;
        bus.blank_mask = 4'b0000;
        repeat (2) tick;
        check("rst_en", 32'(bus.dec_en), 0);
        check("rst_sel", 32'({bus.sel_a, bus.sel_b}), 0);
        check("rst_nib", 32'(bus.nibble), 0);
        check("rst_fd", 32'(bus.frame_done), 0);
        rst = 1'b0;
        repeat (5) tick;
        check("idle_en", 32'(bus.dec_en), 0);
        check("idle_sel", 32'({bus.sel_a, bus.sel_b}), 0);
        bus.run = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tick;
            expect_step("scan", k, 4'b0000, 16'h4321);
        end
        bus.blank_mask = 4'b0100;
        restart;
        for (int k = 1; k <= 24; k++) begin
            tick;
            expect_step("mask", k, 4'b0100, 16'h4321);
        end
        bus.blank_mask = 4'b0000;
        restart;
        for (int k = 1; k <= 18; k++) begin
            tick;
            expect_step("upd", k, 4'b0000, k <= 12 ? 16'h4321 : 16'hABCD);
            if (k == 10) bus.digits = 16'hABCD;
        end
        bus.digits = 16'h4321;
        restart;
        for (int k = 1; k <= 16; k++) begin
            tick;
            expect_step("pre_stop", k, 4'b0000, 16'h4321);
        end
        bus.run = 1'b0;
        tick;
        check("stop_en", 32'(bus.dec_en), 0);
        check("stop_sel", 32'({bus.sel_a, bus.sel_b}), 0);
        check("stop_nib", 32'(bus.nibble), 3);
        check("stop_fd", 32'(bus.frame_done), 0);
        tick;
        check("stop_hold_en", 32'(bus.dec_en), 0);
        bus.run = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            expect_step("resume", k, 4'b0000, 16'h4321);
        end
        #2;
        rst = 1'b1;
        #1;
        check("arst_en", 32'(bus.dec_en), 0);
        check("arst_sel", 32'({bus.sel_a, bus.sel_b}), 0);
        check("arst_nib", 32'(bus.nibble), 0);
        check("arst_fd", 32'(bus.frame_done), 0);
        bus.run = 1'b0;
        tick;
        rst = 1'b0;
        repeat (5) tick;
        check("arst_idle_en", 32'(bus.dec_en), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
